// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory geometry and data-memory arbiter types.
package cpu_pkg;
  localparam int MEM_ADDR_WIDTH = 8;
  localparam int MEM_DATA_WIDTH = 32;

  // Arbiter mode: CPU priority, or one forced host cycle after starvation.
  typedef enum logic {ARB_NORM, ARB_FORCE} dmem_arb_state_t;

  localparam int DMEM_ARB_STARVE_DEFAULT = 4;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Host starvation guard: counts consecutive host cycles lost to the CPU and
// raises o_force_host for exactly one cycle once STARVE_LIMIT is reached.
module dmem_arb_starve_ctr
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = DMEM_ARB_STARVE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_host_req,
  input  logic i_cpu_any,
  output logic o_force_host
);
  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);

  dmem_arb_state_t r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            w_lose;

  // Next state: the host only loses in NORM (FORCE grants any request);
  // losing at the limit enters FORCE, which always lasts one cycle.
  always_comb begin
    w_state_nxt = ARB_NORM;
    w_cnt_nxt   = '0;
    w_lose      = i_host_req & i_cpu_any & (r_state == ARB_NORM);
    if (w_lose) begin
      if (r_cnt == LIM_M1) begin
        w_state_nxt = ARB_FORCE;
      end else begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB_NORM;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_force_host = (r_state == ARB_FORCE);
endmodule

// File: rtl/dmem_arbiter.sv
// Data SRAM arbiter between the CPU load/store port and the host/debug port.
// CPU wins by default. Define DMEM_ARB_STARVE_EN to add the starvation guard
// (forced host grant with a one-cycle CPU stall); otherwise fixed CPU priority.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = cpu_pkg::MEM_ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = cpu_pkg::MEM_DATA_WIDTH,
  parameter int STARVE_LIMIT   = DMEM_ARB_STARVE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_ren,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_raddr,
  input  logic                      cpu_wen,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_waddr,
  input  logic [MEM_DATA_WIDTH-1:0] cpu_wdata,
  output logic [MEM_DATA_WIDTH-1:0] cpu_rdata,
  output logic                      cpu_stall,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [MEM_ADDR_WIDTH-1:0] host_addr,
  input  logic [MEM_DATA_WIDTH-1:0] host_wdata,
  output logic                      host_gnt,
  output logic                      host_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] host_rdata,
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be 1..15");
  end

  logic w_cpu_any;
  logic w_force;
  logic w_host_gnt;
  logic r_rd_host;

  assign w_cpu_any = cpu_ren | cpu_wen;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_host_req  (host_req),
    .i_cpu_any   (w_cpu_any),
    .o_force_host(w_force)
  );
  // Only an actual host request in the forced cycle bumps the CPU.
  assign cpu_stall = w_force & host_req & w_cpu_any;
`else
  assign w_force   = 1'b0;
  assign cpu_stall = 1'b0;
`endif

  // Grant is masked during reset so nothing reaches the host while held.
  assign w_host_gnt = rst & host_req & (~w_cpu_any | w_force);
  assign host_gnt   = w_host_gnt;

  // SRAM port steering: a granted host owns both ports, else CPU passes through.
  always_comb begin
    mem_ren   = cpu_ren;
    mem_raddr = cpu_raddr;
    mem_wen   = cpu_wen;
    mem_waddr = cpu_waddr;
    mem_wdata = cpu_wdata;
    if (w_host_gnt) begin
      mem_ren   = ~host_we;
      mem_raddr = host_addr;
      mem_wen   = host_we;
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Track read ownership for the 1-cycle SRAM return; reset drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_host <= 1'b0;
    else      r_rd_host <= w_host_gnt & ~host_we;
  end

  assign host_rvalid = r_rd_host;
  assign host_rdata  = r_rd_host ? mem_rdata : '0;
  assign cpu_rdata   = mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural SRAM and a
// queue of expected host read returns. Covers both DMEM_ARB_STARVE_EN builds.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_ren, cpu_wen, cpu_stall;
  logic [AW-1:0] cpu_raddr, cpu_waddr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_rdata, mem_wdata;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sram[256];
  logic [DW-1:0] r_q = '0;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_wen(cpu_wen),
    .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous read, 1-cycle latency, read-before-write.
  always @(posedge clk) begin
    if (mem_ren) r_q <= sram[mem_raddr];
    if (mem_wen) sram[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = r_q;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a full input vector right after a falling edge, settle, then compare.
  task automatic drv(input logic cr, input logic [AW-1:0] ra, input logic cw,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic hr, input logic hw, input logic [AW-1:0] ha,
                     input logic [DW-1:0] hd);
    @(negedge clk);
    cpu_ren = cr; cpu_raddr = ra; cpu_wen = cw; cpu_waddr = wa; cpu_wdata = wd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #1;
  endtask

  task automatic chk_ret(input string tag);
    chk({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
    if (exp_q.size() == 0) chk({tag, "_q_empty"}, 32'd1, 32'd0);
    else chk({tag, "_rdata"}, host_rdata, exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = '0;
    rst = 1'b0;
    // Reset: host request and CPU read present; no grant, CPU owns memory.
    drv(1, 8'h03, 0, 0, 0, 1, 0, 8'h10, 0);
    chk("rst_gnt", {31'd0, host_gnt}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_mem_ren", {31'd0, mem_ren}, 32'd1);
    chk("rst_mem_raddr", {24'd0, mem_raddr}, 32'h03);
    @(negedge clk); rst = 1'b1;

    // Host write then read with CPU idle.
    drv(0, 0, 0, 0, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    chk("hw_gnt", {31'd0, host_gnt}, 32'd1);
    chk("hw_mem_wen", {31'd0, mem_wen}, 32'd1);
    chk("hw_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("hw_waddr", {24'd0, mem_waddr}, 32'h10);
    chk("hw_wdata", mem_wdata, 32'hDEADBEEF);
    drv(0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    chk("hr_gnt", {31'd0, host_gnt}, 32'd1);
    chk("hr_mem_ren", {31'd0, mem_ren}, 32'd1);
    chk("hr_raddr", {24'd0, mem_raddr}, 32'h10);
    exp_q.push_back(32'hDEADBEEF);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ret("hr_ret");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hr_after_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("hr_after_rdata", host_rdata, 32'd0);

    // Continuous CPU reads with a pending host write.
    for (int c = 1; c <= LIM; c++) begin
      drv(1, 8'h10, 0, 0, 0, 1, 1, 8'h20, 32'h0000CAFE);
      chk($sformatf("starve_c%0d_gnt", c), {31'd0, host_gnt}, 32'd0);
      chk($sformatf("starve_c%0d_stall", c), {31'd0, cpu_stall}, 32'd0);
      chk($sformatf("starve_c%0d_ren", c), {31'd0, mem_ren}, 32'd1);
    end
`ifdef DMEM_ARB_STARVE_EN
    drv(1, 8'h10, 0, 0, 0, 1, 1, 8'h20, 32'h0000CAFE);
    chk("force_gnt", {31'd0, host_gnt}, 32'd1);
    chk("force_stall", {31'd0, cpu_stall}, 32'd1);
    chk("force_wen", {31'd0, mem_wen}, 32'd1);
    chk("force_ren", {31'd0, mem_ren}, 32'd0);
    chk("force_waddr", {24'd0, mem_waddr}, 32'h20);
    // Back in NORM: a fresh request loses to the busy CPU again.
    drv(1, 8'h10, 0, 0, 0, 1, 1, 8'h21, 32'h00005555);
    chk("post_force_gnt", {31'd0, host_gnt}, 32'd0);
    chk("post_force_stall", {31'd0, cpu_stall}, 32'd0);
    drv(0, 0, 0, 0, 0, 1, 1, 8'h21, 32'h00005555);
    chk("idle_gnt_21", {31'd0, host_gnt}, 32'd1);
`else
    for (int c = LIM + 1; c <= LIM + 3; c++) begin
      drv(1, 8'h10, 0, 0, 0, 1, 1, 8'h20, 32'h0000CAFE);
      chk($sformatf("nostarve_c%0d_gnt", c), {31'd0, host_gnt}, 32'd0);
      chk($sformatf("nostarve_c%0d_stall", c), {31'd0, cpu_stall}, 32'd0);
    end
    drv(0, 0, 0, 0, 0, 1, 1, 8'h20, 32'h0000CAFE);
    chk("idle_gnt_20", {31'd0, host_gnt}, 32'd1);
`endif
    // Read back 0x20 through the host path, then through the CPU path.
    drv(0, 0, 0, 0, 0, 1, 0, 8'h20, 0);
    chk("rb20_gnt", {31'd0, host_gnt}, 32'd1);
    exp_q.push_back(32'h0000CAFE);
    drv(1, 8'h20, 0, 0, 0, 0, 0, 0, 0);
    chk_ret("rb20_ret");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("cpu_rd20", cpu_rdata, 32'h0000CAFE);
    chk("cpu_rd_no_rvalid", {31'd0, host_rvalid}, 32'd0);

    // CPU write and read of the same address in one cycle.
    drv(1, 8'h05, 1, 8'h05, 32'h1234, 0, 0, 0, 0);
    chk("rw_wen", {31'd0, mem_wen}, 32'd1);
    chk("rw_ren", {31'd0, mem_ren}, 32'd1);
    chk("rw_waddr", {24'd0, mem_waddr}, 32'h05);
    chk("rw_wdata", mem_wdata, 32'h1234);
    chk("rw_gnt", {31'd0, host_gnt}, 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rw_rvalid", {31'd0, host_rvalid}, 32'd0);

    // Host read granted, reset before the return cycle.
    drv(0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    chk("rst_rd_gnt", {31'd0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; host_req = 1'b0;
    #1;
    chk("rst_rd_rvalid", {31'd0, host_rvalid}, 32'd0);
    @(negedge clk); rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_rd_rvalid_rel", {31'd0, host_rvalid}, 32'd0);

    // After reset the counter restarts from zero: LIM losses, then the
    // forced cycle where the host drops its request.
    for (int c = 1; c <= LIM; c++) begin
      drv(1, 8'h05, 0, 0, 0, 1, 1, 8'h30, 32'h7777);
      chk($sformatf("drop_c%0d_gnt", c), {31'd0, host_gnt}, 32'd0);
    end
    drv(1, 8'h05, 0, 0, 0, 0, 1, 8'h30, 32'h7777);
    chk("drop_stall", {31'd0, cpu_stall}, 32'd0);
    chk("drop_gnt", {31'd0, host_gnt}, 32'd0);
    chk("drop_ren", {31'd0, mem_ren}, 32'd1);
    chk("drop_raddr", {24'd0, mem_raddr}, 32'h05);
    chk("drop_wen", {31'd0, mem_wen}, 32'd0);
    drv(1, 8'h05, 0, 0, 0, 1, 1, 8'h30, 32'h7777);
    chk("drop_norm_gnt", {31'd0, host_gnt}, 32'd0);
    chk("drop_norm_stall", {31'd0, cpu_stall}, 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("q_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
